// File: rtl/axis_mash11_pkg.sv
// Shared types and constants for the MASH 1-1 delta-sigma modulator.
package axis_mash11_pkg;

  localparam int unsigned MASH_OUT_WIDTH = 3;

  typedef logic signed [MASH_OUT_WIDTH-1:0] mash_out_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_POLY_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY_MASK) : (cur >> 1);
  endfunction

  // y = c1 + c2 - z^-1 c2, which cancels the first-stage quantisation noise.
  function automatic mash_out_t mash_combine(input logic c1, input logic c2, input logic c2_dly);
    mash_out_t a, b, c;
    a = mash_out_t'({2'b00, c1});
    b = mash_out_t'({2'b00, c2});
    c = mash_out_t'({2'b00, c2_dly});
    return a + b - c;
  endfunction

endpackage

// File: rtl/mash11_efm_stage.sv
// First-order error-feedback stage: one wrapping accumulator whose carry-out is the
// quantised output and whose updated sum is the residue fed to the next stage.
module mash11_efm_stage
  import axis_mash11_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic             cin_i,
  output logic             carry_o,
  output logic [WIDTH-1:0] residue_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, x_i} + {{WIDTH{1'b0}}, cin_i};
    carry_o   = sum[WIDTH];
    residue_o = sum[WIDTH-1:0];
    acc_d     = en_i ? sum[WIDTH-1:0] : acc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_mash11_modulator.sv
// MASH 1-1 delta-sigma modulator with AXI-Stream input/output; output in -1..+2.
// Define AXIS_MASH11_DITHER_EN to add LFSR carry-in dither to the first stage.
module axis_mash11_modulator
  import axis_mash11_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 3
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic [WIDTH-1:0]          s_axis_data_tdata,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  output logic [MASH_OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                      m_axis_data_tvalid
);

  if (OUT_WIDTH != MASH_OUT_WIDTH) begin : gen_cfg_err
    $error("axis_mash11_modulator: OUT_WIDTH must be 3");
  end

  logic             accept;
  logic             cin1;
  logic             c1, c2;
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;

  logic      tready_q, tready_d;
  logic      tvalid_q, tvalid_d;
  mash_out_t tdata_q, tdata_d;
  logic      c2_dly_q, c2_dly_d;

  assign accept = s_axis_data_tvalid & tready_q;

`ifdef AXIS_MASH11_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign cin1 = lfsr_q[0];

  always_comb begin
    lfsr_d = accept ? lfsr_next(lfsr_q) : lfsr_q;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign cin1 = 1'b0;
`endif

  mash11_efm_stage #(
    .WIDTH(WIDTH)
  ) u_stage1 (
    .clk_i    (aclk),
    .rst_ni   (arst_n),
    .en_i     (accept),
    .x_i      (s_axis_data_tdata),
    .cin_i    (cin1),
    .carry_o  (c1),
    .residue_o(res1)
  );

  mash11_efm_stage #(
    .WIDTH(WIDTH)
  ) u_stage2 (
    .clk_i    (aclk),
    .rst_ni   (arst_n),
    .en_i     (accept),
    .x_i      (res1),
    .cin_i    (1'b0),
    .carry_o  (c2),
    .residue_o(res2)
  );

  always_comb begin
    tready_d = 1'b1;
    tvalid_d = accept;
    tdata_d  = tdata_q;
    c2_dly_d = c2_dly_q;
    if (accept) begin
      tdata_d  = mash_combine(c1, c2, c2_dly_q);
      c2_dly_d = c2;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      c2_dly_q <= 1'b0;
    end else begin
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      c2_dly_q <= c2_dly_d;
    end
  end

  assign s_axis_data_tready = tready_q;
  assign m_axis_data_tvalid = tvalid_q;
  assign m_axis_data_tdata  = tdata_q;

  // Stage-2 residue is the second accumulator's next value; nothing consumes it here.
  logic unused_res2;
  assign unused_res2 = ^res2;

endmodule

// File: tb/tb_axis_mash11_modulator.sv
// Directed self-checking bench for axis_mash11_modulator (default, undithered build).
module tb_axis_mash11_modulator;

  logic        aclk;
  logic        arst_n;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [2:0]  m_tdata;
  logic        m_tvalid;

  int checks = 0;
  int errors = 0;
  int ys[1024];

  // Hand-derived output sequences from reset.
  int exp_half[8]    = '{0, 1, 1, 0, 0, 1, 1, 0};
  int exp_quarter[8] = '{0, 0, 1, 0, 0, 1, 0, 0};
  int exp_6000[6]    = '{0, 1, 0, 0, 1, 0};

  axis_mash11_modulator #(
    .WIDTH    (16),
    .OUT_WIDTH(3)
  ) dut (
    .aclk              (aclk),
    .arst_n            (arst_n),
    .s_axis_data_tdata (s_tdata),
    .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata (m_tdata),
    .m_axis_data_tvalid(m_tvalid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    arst_n   = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic run_const(input logic [15:0] x, input int n,
                           output int sum, output int bad, output int nz);
    int y;
    sum = 0;
    bad = 0;
    nz  = 0;
    s_tdata  = x;
    s_tvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      y = int'($signed(m_tdata));
      if (i < 1024) ys[i] = y;
      sum += y;
      if (y < -1 || y > 2 || !m_tvalid) bad++;
      if (y != 0) nz++;
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    int sum, bad, nz, last;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    arst_n   = 1'b0;

    // Reset and idle
    tick();
    tick();
    check_eq("rst_tready", int'(s_tready), 0);
    check_eq("rst_mvalid", int'(m_tvalid), 0);
    check_eq("rst_mdata", int'(m_tdata), 0);
    arst_n = 1'b1;
    tick();
    check_eq("tready_after_release", int'(s_tready), 1);

    // Zero input
    run_const(16'h0000, 256, sum, bad, nz);
    check_eq("zero_nonzero_count", nz, 0);
    check_eq("zero_bad_count", bad, 0);

    // Half scale
    do_reset();
    run_const(16'h8000, 1024, sum, bad, nz);
    for (int i = 0; i < 8; i++) check_eq($sformatf("half_y%0d", i), ys[i], exp_half[i]);
    check_eq("half_sum", sum, 512);
    check_eq("half_bad_count", bad, 0);

    // Quarter scale
    do_reset();
    run_const(16'h4000, 64, sum, bad, nz);
    for (int i = 0; i < 8; i++) check_eq($sformatf("quarter_y%0d", i), ys[i], exp_quarter[i]);
    check_eq("quarter_sum", sum, 16);
    check_eq("quarter_bad_count", bad, 0);

    // Near full scale: second sample exercises the +2 level
    do_reset();
    run_const(16'hFFFF, 1024, sum, bad, nz);
    check_eq("full_y0", ys[0], 0);
    check_eq("full_y1", ys[1], 2);
    check_eq("full_y2", ys[2], 1);
    check_eq("full_sum_within_2", int'(sum >= 1022 && sum <= 1026), 1);
    check_eq("full_bad_count", bad, 0);

    // tvalid gaps: accepted outputs follow the gap-free sequence, data holds in gaps
    do_reset();
    s_tdata = 16'h8000;
    last = 0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = (i % 2 == 0);
      tick();
      check_eq($sformatf("gap_mvalid%0d", i), int'(m_tvalid), (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("gap_mdata%0d", i), int'($signed(m_tdata)), exp_half[i / 2]);
    end
    s_tvalid = 1'b0;

    // Asynchronous reset mid-stream
    do_reset();
    run_const(16'h6000, 5, sum, bad, nz);
    for (int i = 0; i < 5; i++) check_eq($sformatf("pre_rst_y%0d", i), ys[i], exp_6000[i]);
    #2;
    arst_n = 1'b0;
    #1;
    check_eq("midrst_mdata", int'(m_tdata), 0);
    check_eq("midrst_mvalid", int'(m_tvalid), 0);
    check_eq("midrst_tready", int'(s_tready), 0);
    tick();
    arst_n = 1'b1;
    tick();
    check_eq("midrst_tready_back", int'(s_tready), 1);
    run_const(16'h6000, 6, sum, bad, nz);
    for (int i = 0; i < 6; i++) check_eq($sformatf("post_rst_y%0d", i), ys[i], exp_6000[i]);
    tick();
    check_eq("post_rst_mvalid_drop", int'(m_tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
